// File: rtl/multu_seq.sv
// multu_seq: sequential 32x32 unsigned shift-add multiplier feeding the Hi/Lo block.
// Optional early termination is enabled by defining MULTU_SEQ_EARLY_TERM_EN.
module multu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  op_in,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic [5:0]  op_out,
    output logic [63:0] MulAns
);

    localparam logic [5:0] MULTU = 6'd25;
    localparam logic [5:0] MADDU = 6'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [5:0]  op_r;
    logic [63:0] mcand_r;
    logic [31:0] mplr_r;
    logic [63:0] acc_r;
    logic [5:0]  count_r;
    logic        busy_r;
    logic        done_r;
    logic [5:0]  op_out_r;
    logic [63:0] mul_ans_r;
    logic        accept_s;
    logic        last_step_s;
    logic [63:0] step_sum_s;

    function automatic logic valid_op(input logic [5:0] op);
        return (op == MULTU) || (op == MADDU);
    endfunction

    // Partial-product accumulate and loop-exit decision for the current RUN step
    always_comb begin
        step_sum_s  = acc_r;
        last_step_s = 1'b0;
        if (mplr_r[0]) begin
            step_sum_s = acc_r + mcand_r;
        end else begin
            step_sum_s = acc_r;
        end
`ifdef MULTU_SEQ_EARLY_TERM_EN
        // Stop once no set multiplier bits remain after this step's shift
        last_step_s = (count_r == 6'd31) || (mplr_r[31:1] == 31'd0);
`else
        last_step_s = (count_r == 6'd31);
`endif
    end

    // Next-state logic and request acceptance
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && valid_op(op_in)) begin
                    accept_s     = 1'b1;
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (last_step_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Datapath and registered outputs; MulAns loads only on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r      <= 6'd0;
            mcand_r   <= 64'd0;
            mplr_r    <= 32'd0;
            acc_r     <= 64'd0;
            count_r   <= 6'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            op_out_r  <= 6'd0;
            mul_ans_r <= 64'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r   <= 1'b0;
                    op_out_r <= 6'd0;
                    if (accept_s) begin
                        op_r    <= op_in;
                        mcand_r <= {32'd0, src_a};
                        mplr_r  <= src_b;
                        acc_r   <= 64'd0;
                        count_r <= 6'd0;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                RUN: begin
                    acc_r   <= step_sum_s;
                    mcand_r <= mcand_r << 1;
                    mplr_r  <= mplr_r >> 1;
                    count_r <= count_r + 6'd1;
                    if (last_step_s) begin
                        done_r    <= 1'b1;
                        op_out_r  <= op_r;
                        mul_ans_r <= step_sum_s;
                    end else begin
                        done_r    <= 1'b0;
                        op_out_r  <= 6'd0;
                    end
                end
                DONE: begin
                    done_r   <= 1'b0;
                    op_out_r <= 6'd0;
                    busy_r   <= 1'b0;
                end
                default: begin
                    done_r   <= 1'b0;
                    op_out_r <= 6'd0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign op_out = op_out_r;
    assign MulAns = mul_ans_r;

endmodule

// File: tb/tb_multu_seq.sv
// Self-checking bench for multu_seq: directed spec cases plus randomized operations
// checked against an arithmetic reference model (honours MULTU_SEQ_EARLY_TERM_EN).
module tb_multu_seq;

    localparam logic [5:0] MULTU = 6'd25;
    localparam logic [5:0] MADDU = 6'd1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  op_in;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [5:0]  op_out;
    logic [63:0] MulAns;

    int checks   = 0;
    int failures = 0;

    multu_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_in  (op_in),
        .src_a  (src_a),
        .src_b  (src_b),
        .busy   (busy),
        .done   (done),
        .op_out (op_out),
        .MulAns (MulAns)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Edges from the accepting edge (inclusive) until done is visible
    function automatic int exp_latency(input logic [31:0] b);
`ifdef MULTU_SEQ_EARLY_TERM_EN
        int steps = 1;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) steps = i + 1;
        end
        return steps + 1;
`else
        return 33;
`endif
    endfunction

    // Watch n cycles and report whether done or op_out ever became active
    task automatic quiet_window(input string tag, input int n);
        logic seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || op_out !== 6'd0 || busy !== 1'b0) seen = 1'b1;
        end
        check(tag, {63'd0, seen}, 64'd0);
    endtask

    task automatic do_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit poke_mid);
        int          cycles;
        int          busy_cycles;
        logic        stray;
        logic [63:0] prev_ans;
        logic [63:0] exp_prod;
        exp_prod = 64'(a) * 64'(b);
        prev_ans = MulAns;
        stray    = 1'b0;
        @(negedge clk);
        start = 1'b1; op_in = op; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0; op_in = 6'($urandom); src_a = $urandom; src_b = $urandom;
        cycles = 1;
        busy_cycles = 0;
        while (done !== 1'b1 && cycles < 100) begin
            if (busy !== 1'b1 || op_out !== 6'd0 || MulAns !== prev_ans) stray = 1'b1;
            busy_cycles++;
            if (poke_mid && cycles == 5) begin
                start = 1'b1; op_in = MULTU; src_a = 32'd3; src_b = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        if (busy === 1'b1) busy_cycles++;
        check({tag, "_latency"}, 64'(cycles), 64'(exp_latency(b)));
        check({tag, "_run_quiet"}, {63'd0, stray}, 64'd0);
        check({tag, "_product"}, MulAns, exp_prod);
        check({tag, "_op_out"}, {58'd0, op_out}, {58'd0, op});
        check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(exp_latency(b)));
        @(negedge clk);
        check({tag, "_after"}, {done, busy, op_out}, 8'd0);
        check({tag, "_hold"}, MulAns, exp_prod);
    endtask

    initial begin
        logic [5:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1; start = 1'b0; op_in = 6'd0; src_a = 32'd0; src_b = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_ctrl", {62'd0, busy, done}, 64'd0);
        check("reset_op_out", {58'd0, op_out}, 64'd0);
        check("reset_ans", MulAns, 64'd0);

        // Invalid opcode is ignored
        start = 1'b1; op_in = 6'd0; src_a = 32'd5; src_b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        check("bad_op_busy", {63'd0, busy}, 64'd0);
        quiet_window("bad_op_quiet", 40);
        check("bad_op_ans", MulAns, 64'd0);

        do_op("multu_3x5", MULTU, 32'd3, 32'd5, 1'b0);
        do_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op("maddu_pow", MADDU, 32'h0001_0000, 32'h0001_0000, 1'b1);
        quiet_window("maddu_no_second", 40);

        // Reset mid-RUN discards the operation
        @(negedge clk);
        start = 1'b1; op_in = MULTU; src_a = 32'd7; src_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", {62'd0, busy, done}, 64'd0);
        check("rst_mid_ans", MulAns, 64'd0);
        quiet_window("rst_mid_quiet", 40);
        do_op("after_rst", MULTU, 32'd7, 32'd9, 1'b0);

        // Early-termination boundary operands (fixed build expects 33 throughout)
        do_op("b_one", MULTU, 32'd42, 32'd1, 1'b0);
        do_op("b_msb", MADDU, 32'd42, 32'h8000_0000, 1'b0);
        do_op("b_zero", MULTU, 32'hDEAD_BEEF, 32'd0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rop = ($urandom_range(0, 1) == 0) ? MULTU : MADDU;
            ra  = $urandom;
            rb  = $urandom >> $urandom_range(0, 31);
            do_op("random", rop, ra, rb, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
